// File: rtl/h_msg_schedule.sv
// rtl/h_msg_schedule.sv - SHA-256/512 message schedule: serial 16-word load, then one W_t per round.
// Optional SHA_SCHED_ZEROIZE_EN clears the shift register and wt on every return to IDLE.
module h_msg_schedule #(
    parameter int DW = 64,
    parameter int NW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic          abort,
    input  logic          msg_valid,
    input  logic [DW-1:0] msg_data,
    output logic          msg_ready,
    output logic          loaded,
    input  logic          start,
    output logic          round_init,
    output logic          mode_q,
    output logic [DW-1:0] wt,
    output logic          wt_valid,
    output logic          wt_last
);

    localparam int CW = $clog2(NW);

    typedef enum logic [1:0] {IDLE, LOAD, READY, RUN} state_t;

    state_t        state, state_next;
    logic [DW-1:0] w [NW];
    logic [CW-1:0] count;
    logic [6:0]    t;
    logic [6:0]    last_t;
    logic          accept;
    logic          do_shift;
    logic          word_mode;
    logic [DW-1:0] word_in;
    logic [DW-1:0] w_new;
    logic [31:0]   sum32;
    logic [63:0]   sum64;

    function automatic logic [31:0] s0_32(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1_32(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic logic [63:0] s0_64(input logic [63:0] x);
        return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
    endfunction

    function automatic logic [63:0] s1_64(input logic [63:0] x);
        return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
    endfunction

    // The first word of a block is stored under the live mode input, later words under the latched one.
    assign word_mode = (state == IDLE) ? mode : mode_q;
    assign word_in   = word_mode ? msg_data : {{(DW-32){1'b0}}, msg_data[31:0]};
    assign last_t    = mode_q ? 7'd79 : 7'd63;

    always_comb begin
        sum64 = s1_64(w[14]) + w[9] + s0_64(w[1]) + w[0];
        sum32 = s1_32(w[14][31:0]) + w[9][31:0] + s0_32(w[1][31:0]) + w[0][31:0];
        w_new = mode_q ? sum64 : {{(DW-32){1'b0}}, sum32};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        round_init = 1'b0;
        do_shift   = 1'b0;
        msg_ready  = (state == IDLE) || (state == LOAD);
        loaded     = (state == READY);
        case (state)
            IDLE: begin
                if (msg_valid && !abort) begin
                    accept     = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (msg_valid && !abort) begin
                    accept = 1'b1;
                    if (count == CW'(NW-1)) begin
                        state_next = READY;
                    end
                end
            end
            READY: begin
                if (start && !abort) begin
                    round_init = 1'b1;
                    do_shift   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!abort) begin
                    if (t == last_t) begin
                        state_next = IDLE;
                    end else begin
                        do_shift = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    // wt is taken from w[0] in the same edge that shifts the register, so W0 appears one cycle after start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= 1'b0;
            count    <= '0;
            t        <= '0;
            wt       <= '0;
            wt_valid <= 1'b0;
            wt_last  <= 1'b0;
            for (int i = 0; i < NW; i++) begin
                w[i] <= '0;
            end
        end else if (abort) begin
            count    <= '0;
            t        <= '0;
            wt_valid <= 1'b0;
            wt_last  <= 1'b0;
`ifdef SHA_SCHED_ZEROIZE_EN
            wt <= '0;
            for (int i = 0; i < NW; i++) begin
                w[i] <= '0;
            end
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mode_q <= mode;
                        w[0]   <= word_in;
                        count  <= CW'(1);
                    end
                end
                LOAD: begin
                    if (accept) begin
                        w[count] <= word_in;
                        count    <= count + 1'b1;
                    end
                end
                READY: begin
                    if (round_init) begin
                        t        <= '0;
                        wt_valid <= 1'b1;
                        wt_last  <= 1'b0;
                    end
                end
                RUN: begin
                    if (t == last_t) begin
                        t        <= '0;
                        count    <= '0;
                        wt_valid <= 1'b0;
                        wt_last  <= 1'b0;
`ifdef SHA_SCHED_ZEROIZE_EN
                        wt <= '0;
                        for (int i = 0; i < NW; i++) begin
                            w[i] <= '0;
                        end
`endif
                    end else begin
                        t       <= t + 7'd1;
                        wt_last <= ((t + 7'd1) == last_t);
                    end
                end
                default: ;
            endcase
            if (do_shift) begin
                wt <= w[0];
                for (int i = 0; i < NW-1; i++) begin
                    w[i] <= w[i+1];
                end
                w[NW-1] <= w_new;
            end
        end
    end

endmodule

// File: tb/tb_h_msg_schedule.sv
// tb/tb_h_msg_schedule.sv - randomized self-checking bench for h_msg_schedule against a W_t array model.
module tb_h_msg_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        abort;
    logic        msg_valid;
    logic [63:0] msg_data;
    logic        msg_ready;
    logic        loaded;
    logic        start;
    logic        round_init;
    logic        mode_q;
    logic [63:0] wt;
    logic        wt_valid;
    logic        wt_last;

    int total = 0;
    int bad   = 0;

    logic [63:0] blk   [16];
    logic [63:0] exp_w [80];
    logic [63:0] got_w [80];

    h_msg_schedule #(.DW(64), .NW(16)) dut (
        .clk(clk), .rst(rst), .mode(mode), .abort(abort),
        .msg_valid(msg_valid), .msg_data(msg_data), .msg_ready(msg_ready),
        .loaded(loaded), .start(start), .round_init(round_init), .mode_q(mode_q),
        .wt(wt), .wt_valid(wt_valid), .wt_last(wt_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input bit m);
        logic [31:0] y;
        if (m) return (x >> n) | (x << (64 - n));
        y = x[31:0];
        return {32'b0, (y >> n) | (y << (32 - n))};
    endfunction

    function automatic logic [63:0] sg0(input logic [63:0] x, input bit m);
        if (m) return rotr(x, 1, 1) ^ rotr(x, 8, 1) ^ (x >> 7);
        return rotr(x, 7, 0) ^ rotr(x, 18, 0) ^ (x >> 3);
    endfunction

    function automatic logic [63:0] sg1(input logic [63:0] x, input bit m);
        if (m) return rotr(x, 19, 1) ^ rotr(x, 61, 1) ^ (x >> 6);
        return rotr(x, 17, 0) ^ rotr(x, 19, 0) ^ (x >> 10);
    endfunction

    task automatic build_exp(input bit m);
        logic [63:0] s;
        for (int i = 0; i < 16; i++) exp_w[i] = m ? blk[i] : {32'b0, blk[i][31:0]};
        for (int i = 16; i < 80; i++) begin
            s = sg1(exp_w[i-2], m) + exp_w[i-7] + sg0(exp_w[i-15], m) + exp_w[i-16];
            exp_w[i] = m ? s : {32'b0, s[31:0]};
        end
    endtask

    task automatic random_block();
        for (int i = 0; i < 16; i++) blk[i] = {$urandom, $urandom};
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_msg_ready"}, msg_ready, 1);
        check({tag, "_loaded"}, loaded, 0);
        check({tag, "_round_init"}, round_init, 0);
        check({tag, "_mode_q"}, mode_q, 0);
        check({tag, "_wt"}, wt, 0);
        check({tag, "_wt_valid"}, wt_valid, 0);
        check({tag, "_wt_last"}, wt_last, 0);
    endtask

    task automatic load_block(input bit m, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    msg_valid = 1'b0;
                    start     = 1'($urandom_range(0, 1));
                    #1;
                    check("round_init_in_load", round_init, 0);
                    tick();
                    check("loaded_early", loaded, 0);
                end
            end
            start     = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            msg_valid = 1'b1;
            msg_data  = blk[i];
            mode      = (i == 0) ? m : ~m;
            check("msg_ready_load", msg_ready, 1);
            tick();
        end
        msg_valid = 1'b0;
        start     = 1'b0;
        #1;
        check("loaded", loaded, 1);
        check("msg_ready_ready", msg_ready, 0);
        check("mode_q", mode_q, m);
    endtask

    task automatic run_block(input bit m, input int abort_at);
        int n;
        n = m ? 80 : 64;
        build_exp(m);
        start = 1'b1;
        #1;
        check("round_init_pulse", round_init, 1);
        tick();
        start = 1'b0;
        #1;
        check("round_init_low", round_init, 0);
        for (int i = 0; i < n; i++) begin
            check("wt_valid", wt_valid, 1);
            check("wt", wt, exp_w[i]);
            check("wt_last", wt_last, (i == n - 1) ? 64'd1 : 64'd0);
            got_w[i] = wt;
            if (i == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                #1;
                check("abort_wt_valid", wt_valid, 0);
                check("abort_wt_last", wt_last, 0);
                check("abort_msg_ready", msg_ready, 1);
                check("abort_round_init", round_init, 0);
`ifdef SHA_SCHED_ZEROIZE_EN
                check("abort_zeroize_wt", wt, 0);
`endif
                return;
            end
            tick();
        end
        check("end_wt_valid", wt_valid, 0);
        check("end_wt_last", wt_last, 0);
        check("end_msg_ready", msg_ready, 1);
`ifdef SHA_SCHED_ZEROIZE_EN
        check("end_zeroize_wt", wt, 0);
`else
        check("end_wt_hold", wt, exp_w[n-1]);
`endif
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; abort = 1'b0; msg_valid = 1'b0; msg_data = '0; start = 1'b0;
        #12;
        reset_checks("reset");
        rst = 1'b0;
        tick();

        // SHA-256 "abc"
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0] = 64'h61626380; blk[15] = 64'h18;
        load_block(0, 0);
        run_block(0, -1);
        check("abc256_w16", got_w[16], 64'h61626380);
        check("abc256_w17", got_w[17], 64'h000F0000);

        // SHA-512 "abc"
        blk[0] = 64'h6162638000000000;
        load_block(1, 0);
        run_block(1, -1);
        check("abc512_w16", got_w[16], 64'h6162638000000000);
        check("abc512_w17", got_w[17], 64'h00030000000000C0);

        // gapped loads with stray start pulses
        for (int k = 0; k < 4; k++) begin
            random_block();
            load_block(1'(k), 1);
            run_block(1'(k), -1);
        end

        // abort at t=30, then a following block
        random_block();
        load_block(0, 0);
        run_block(0, 30);
        random_block();
        load_block(1, 0);
        run_block(1, -1);

        // abort mid-LOAD wins over a simultaneous handshake
        random_block();
        msg_valid = 1'b1; mode = 1'b1;
        for (int i = 0; i < 5; i++) begin msg_data = blk[i]; tick(); end
        abort = 1'b1; msg_data = blk[5];
        tick();
        abort = 1'b0; msg_valid = 1'b0;
        check("abort_load_loaded", loaded, 0);
        check("abort_load_msg_ready", msg_ready, 1);
        load_block(0, 0);
        run_block(0, -1);

        // asynchronous reset mid-LOAD
        random_block();
        msg_valid = 1'b1; mode = 1'b1;
        for (int i = 0; i < 7; i++) begin msg_data = blk[i]; tick(); end
        msg_valid = 1'b0;
        #2 rst = 1'b1;
        #1 reset_checks("rst_load");
        tick();
        rst = 1'b0;
        load_block(1, 0);
        run_block(1, -1);

        // asynchronous reset mid-RUN
        random_block();
        load_block(1, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        #2 rst = 1'b1;
        #1 reset_checks("rst_run");
        tick();
        rst = 1'b0;
        random_block();
        load_block(0, 1);
        run_block(0, -1);

        // back-to-back blocks, mode 0 then mode 1
        random_block();
        load_block(0, 0);
        run_block(0, -1);
        random_block();
        load_block(1, 0);
        run_block(1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
